// File: rtl/sound_req_arbiter.sv
// -----------------------------------------------------------------------------
// sound_req_arbiter
//
// Collects game sound events (key presses, hole/border/ball collisions) from
// NUM_SRC sources and latches the rising edge of each one as a pending request.
// Pending requests are granted one at a time, lowest index first, to the single
// tone generator. Each granted sound plays for PLAY_CYCLES clocks and is
// followed by GAP_CYCLES clocks of silence.
//
// Optional feature macro: SOUND_ARB_PREEMPT_EN
//   Defined   - a higher-priority request restarts playback immediately with
//               the new sound. The interrupted sound is dropped.
//   Undefined - a sound always plays to completion and pending requests wait.
//
// Ports:
//   clk          system clock
//   resetN       synchronous active-low reset
//   req_in       event levels, one bit per source
//   enable       audio enable; low mutes playback and flushes pending requests
//   play_start   one-cycle pulse when a sound is granted
//   play_active  high while a sound is playing
//   play_sel     index of the most recently granted sound (held outside PLAY)
//   pending      latched requests that have not been served yet
// -----------------------------------------------------------------------------
module sound_req_arbiter #(
    parameter int NUM_SRC     = 6,
    parameter int PLAY_CYCLES = 5000000,
    parameter int GAP_CYCLES  = 500000,
    parameter int CNT_W       = 23,
    parameter int SEL_W       = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic [NUM_SRC-1:0] req_in,
    input  logic               enable,
    output logic               play_start,
    output logic               play_active,
    output logic [SEL_W-1:0]   play_sel,
    output logic [NUM_SRC-1:0] pending
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PLAY_LOAD = CNT_W'(PLAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_SRC-1:0] SRC_ONE = {{(NUM_SRC-1){1'b0}}, 1'b1};

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [NUM_SRC-1:0] req_prev_r;
    logic [NUM_SRC-1:0] pending_r;
    logic               play_start_r;
    logic               play_active_r;
    logic [SEL_W-1:0]   play_sel_r;

    logic [NUM_SRC-1:0] edge_s;
    logic [NUM_SRC-1:0] grant_mask_s;
    logic [NUM_SRC-1:0] pending_nxt_s;
    logic [SEL_W-1:0]   winner_s;
    logic               any_pend_s;
    logic               grant_s;
    logic               preempt_s;

    // Index of the lowest set bit; scanning downward lets the lowest index win.
    function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_SRC-1:0] vec);
        logic [SEL_W-1:0] idx;
        idx = {SEL_W{1'b0}};
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = SEL_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Edge detection, arbitration on the registered pending vector, and next pending.
    always_comb begin
        edge_s     = req_in & ~req_prev_r;
        any_pend_s = |pending_r;
        winner_s   = lowest_set(pending_r);
        preempt_s  = 1'b0;
`ifdef SOUND_ARB_PREEMPT_EN
        preempt_s  = (state_r == PLAY) && enable && any_pend_s && (winner_s < play_sel_r);
`endif
        grant_s    = ((state_r == IDLE) && enable && any_pend_s) || preempt_s;
        if (grant_s) begin
            grant_mask_s = SRC_ONE << winner_s;
        end else begin
            grant_mask_s = {NUM_SRC{1'b0}};
        end
        // A new edge re-arms a bit even if the same bit is being granted now.
        if (enable) begin
            pending_nxt_s = (pending_r & ~grant_mask_s) | edge_s;
        end else begin
            pending_nxt_s = {NUM_SRC{1'b0}};
        end
    end

    // Request history, pending latch and the play/gap sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_r       <= IDLE;
            cnt_r         <= CNT_ZERO;
            req_prev_r    <= {NUM_SRC{1'b0}};
            pending_r     <= {NUM_SRC{1'b0}};
            play_start_r  <= 1'b0;
            play_active_r <= 1'b0;
            play_sel_r    <= {SEL_W{1'b0}};
        end else begin
            req_prev_r   <= req_in;
            pending_r    <= pending_nxt_s;
            play_start_r <= grant_s;
            if (grant_s) begin
                play_sel_r <= winner_s;
            end else begin
                play_sel_r <= play_sel_r;
            end

            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        cnt_r         <= PLAY_LOAD;
                        state_r       <= PLAY;
                        play_active_r <= 1'b1;
                    end else begin
                        play_active_r <= 1'b0;
                    end
                end
                PLAY: begin
                    if (!enable) begin
                        cnt_r         <= CNT_ZERO;
                        state_r       <= IDLE;
                        play_active_r <= 1'b0;
                    end else if (preempt_s) begin
                        // Restart playback with the higher-priority sound.
                        cnt_r         <= PLAY_LOAD;
                        play_active_r <= 1'b1;
                    end else if (cnt_r == CNT_ZERO) begin
                        play_active_r <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            cnt_r   <= GAP_LOAD;
                            state_r <= GAP;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        cnt_r         <= cnt_r - CNT_ONE;
                        play_active_r <= 1'b1;
                    end
                end
                GAP: begin
                    play_active_r <= 1'b0;
                    if (!enable || (cnt_r == CNT_ZERO)) begin
                        cnt_r   <= CNT_ZERO;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    cnt_r         <= CNT_ZERO;
                    state_r       <= IDLE;
                    play_active_r <= 1'b0;
                end
            endcase
        end
    end

    assign play_start  = play_start_r;
    assign play_active = play_active_r;
    assign play_sel    = play_sel_r;
    assign pending     = pending_r;

endmodule
